// File: rtl/uart_arb_pkg.sv
// Shared types for the uart_tx arbiter: FSM encoding, debug view and pointer sizing.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  // Pointer is zero-extended to 3 bits so the view is independent of N_REQ.
  typedef struct packed {
    state_t     state;
    logic [7:0] burst;
    logic [2:0] ptr;
  } dbg_t;

  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte lanes plus the uart_tx send/active pair, bundled for the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  // Lane i: requester holds req_valid/req_data/req_last stable until the arbiter
  // returns a one-cycle req_ready[i] pulse; that pulse is the only acceptance.
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic               tx_active;

  modport slave (
    input  req_valid, req_data, req_last, tx_active,
    output req_ready, grant, busy, tx_data, tx_send
  );

  modport master (
    output req_valid, req_data, req_last, tx_active,
    input  req_ready, grant, busy, tx_data, tx_send
  );
endinterface

// File: rtl/rr_pick.sv
// Rotate-priority search: first set request at or above the pointer, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_any
);

  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_rot_pick;
  logic             w_found;

  // Rotate so the pointer lane sits at bit 0, pick lowest, rotate back.
  assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_found    = 1'b0;
    w_rot_pick = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_rot_pick[k] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_pick = N_REQ'(({w_rot_pick, w_rot_pick} << i_ptr) >> N_REQ);
  assign o_any  = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin owner of a single uart_tx; sequences its send/active handshake.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int ACT_WAIT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output dbg_t               o_dbg
);

  localparam int         PTR_W     = ptr_width(N_REQ);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [7:0] WAIT_LAST = (ACT_WAIT > 1) ? 8'(ACT_WAIT - 1) : 8'd0;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_req_ready;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_burst;
  logic [7:0]       r_wait;
  logic [7:0]       r_tx_data;
  logic             r_tx_send;
  logic             r_busy;
  logic             r_last;

  logic [N_REQ-1:0] w_pick;
  logic             w_any;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [7:0]       w_sel_data;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_ptr_next;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req  (bus.req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    w_gidx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_sel_data = w_sel_data | bus.req_data[8*i +: 8];
        w_gidx     = PTR_W'(i);
      end
    end
  end

  assign w_sel_valid = |(bus.req_valid & r_grant);
  assign w_sel_last  = |(bus.req_last & r_grant);
  assign w_ptr_next  = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_ptr       <= '0;
      r_burst     <= '0;
      r_wait      <= '0;
      r_tx_data   <= '0;
      r_tx_send   <= 1'b0;
      r_busy      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_tx_send   <= 1'b0;
      r_req_ready <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_burst <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!w_sel_valid) begin
            r_ptr   <= w_ptr_next;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (!bus.tx_active) begin
            // Also the guard after reset: a frame left running by uart_tx must finish first.
            r_tx_data   <= w_sel_data;
            r_tx_send   <= 1'b1;
            r_req_ready <= r_grant;
            r_last      <= w_sel_last;
            if (r_burst < BURST_MAX) r_burst <= r_burst + 8'd1;
            r_wait      <= '0;
            r_state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          // Bridge the gap between tx_send and tx_active rising so it is not taken as done.
          if (bus.tx_active || (r_wait >= WAIT_LAST)) r_state <= WAIT_DONE;
          else r_wait <= r_wait + 8'd1;
        end
        WAIT_DONE: begin
          if (!bus.tx_active) begin
            if (r_last || (r_burst == BURST_MAX)) begin
              r_ptr   <= w_ptr_next;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_send   = r_tx_send;

  assign o_dbg = '{state: r_state, burst: r_burst, ptr: 3'(r_ptr)};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: uart_tx model, lane drivers, byte scoreboard.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int AW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  dbg_t dbg;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .ACT_WAIT(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .o_dbg (dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // uart_tx model: never reset, active for m_frame cycles starting m_delay+1 cycles after send
  int m_frame = 20;
  int m_delay = 0;
  int m_rem   = 0;
  int m_dly   = 0;
  assign bus.tx_active = (m_rem != 0);

  always @(posedge clk) begin
    if (bus.tx_send) begin
      if (m_delay == 0) m_rem <= m_frame;
      else m_dly <= m_delay;
    end else if (m_dly != 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1) m_rem <= m_frame;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
    end
  end

  // lane drivers: each lane presents the head of its queue until it sees req_ready
  logic [8:0] src_q [N][$];

  always @(negedge clk) begin
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      if (src_q[i].size() != 0) begin
        v[i]         = 1'b1;
        l[i]         = src_q[i][0][8];
        d[8*i +: 8]  = src_q[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  end

  function automatic logic [2:0] lane_of(input logic [N-1:0] r);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 0; i < N; i++) if (r[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic all_src_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // scoreboard: {lane, byte} in expected service order
  logic [10:0] exp_q[$];
  int m_sends = 0;

  always @(negedge clk) begin
    logic [10:0] obs;
    logic [10:0] e;
    check("rdy_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
    check("rdy_in_grant", 32'(bus.req_ready & ~bus.grant), 32'd0);
    check("send_eq_rdy", 32'(bus.tx_send), 32'(|bus.req_ready));
    if (bus.tx_send) begin
      m_sends++;
      check("send_while_idle", 32'(bus.tx_active), 32'd0);
      obs = {lane_of(bus.req_ready), bus.tx_data};
      e   = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
      check("sb_byte", 32'(obs), 32'(e));
    end
  end

  task automatic push_src(input int lane, input logic last, input logic [7:0] b);
    src_q[lane].push_back({last, b});
  endtask

  task automatic expect_byte(input int lane, input logic [7:0] b);
    exp_q.push_back({3'(lane), b});
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_send", 32'(bus.tx_send), 32'd0);
      check("rst_data", 32'(bus.tx_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_dbg", 32'(dbg), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && all_src_empty() && (dbg.state == IDLE) && !bus.tx_active;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_grant0"}, 32'(bus.grant), 32'd0);
    check({tag, "_busy0"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int  s0;
    int  c;
    int  fall_cyc;
    int  send2_cyc;
    logic prev_act;
    logic hit;

    do_reset(3);

    // 1: single two-byte packet on lane 0, latency and back-to-back spacing
    @(posedge clk);
    #1;
    push_src(0, 1'b0, 8'h41);
    push_src(0, 1'b1, 8'h42);
    expect_byte(0, 8'h41);
    expect_byte(0, 8'h42);
    s0 = m_sends;
    @(negedge clk);
    check("t1_c0_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    check("t1_c1_grant", 32'(bus.grant), 32'b0001);
    check("t1_c1_send", 32'(bus.tx_send), 32'd0);
    check("t1_c1_state", 32'(dbg.state), 32'(LOAD));
    @(negedge clk);
    check("t1_c2_send", 32'(bus.tx_send), 32'd1);
    check("t1_c2_data", 32'(bus.tx_data), 32'h41);
    check("t1_c2_ready", 32'(bus.req_ready), 32'b0001);
    prev_act  = bus.tx_active;
    fall_cyc  = -1;
    send2_cyc = -1;
    for (c = 1; c < 120; c++) begin
      @(negedge clk);
      check("t1_grant", 32'(bus.grant), bus.busy ? 32'b0001 : 32'd0);
      if (prev_act && !bus.tx_active && fall_cyc < 0) fall_cyc = c;
      if (bus.tx_send) send2_cyc = c;
      prev_act = bus.tx_active;
      if (!bus.busy) break;
    end
    check("t1_b2b_gap", 32'(send2_cyc - fall_cyc), 32'd2);
    wait_idle("t1", 40);
    check("t1_sends", 32'(m_sends - s0), 32'd2);

    // 2: three simultaneous one-byte packets after a reset (pointer 0), lane 0 requeues
    do_reset(2);
    push_src(0, 1'b1, 8'ha0);
    push_src(0, 1'b1, 8'ha3);
    push_src(1, 1'b1, 8'ha1);
    push_src(2, 1'b1, 8'ha2);
    expect_byte(0, 8'ha0);
    expect_byte(1, 8'ha1);
    expect_byte(2, 8'ha2);
    expect_byte(0, 8'ha3);
    s0  = m_sends;
    hit = 1'b0;
    for (c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      hit = (m_sends - s0 == 3) && (bus.grant == 4'b0001);
    end
    check("t2_regrant0", 32'(hit), 32'd1);
    check("t2_ptr_after2", 32'(dbg.ptr), 32'd3);
    wait_idle("t2", 200);
    check("t2_ptr_end", 32'(dbg.ptr), 32'd1);

    // 3: lane 1 streams 10 bytes without last; burst cap releases it for lane 2
    for (int i = 0; i < 10; i++) push_src(1, 1'b0, 8'(8'h10 + i));
    push_src(2, 1'b1, 8'h20);
    for (int i = 0; i < 4; i++) expect_byte(1, 8'(8'h10 + i));
    expect_byte(2, 8'h20);
    for (int i = 4; i < 10; i++) expect_byte(1, 8'(8'h10 + i));
    s0 = m_sends;
    wait_idle("t3", 800);
    check("t3_sends", 32'(m_sends - s0), 32'd11);
    check("t3_burst", 32'(dbg.burst), 32'd2);
    check("t3_ptr", 32'(dbg.ptr), 32'd2);

    // 4: lane 3 stalls after one byte; grant moves to waiting lane 0 without a send
    push_src(3, 1'b0, 8'h31);
    push_src(0, 1'b1, 8'h01);
    expect_byte(3, 8'h31);
    expect_byte(0, 8'h01);
    s0  = m_sends;
    hit = 1'b0;
    for (c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      hit = (bus.grant == 4'b0001);
    end
    check("t4_moved", 32'(hit), 32'd1);
    check("t4_one_send", 32'(m_sends - s0), 32'd1);
    wait_idle("t4", 200);
    check("t4_ptr", 32'(dbg.ptr), 32'd1);

    // 5: reset while uart_tx is mid-frame; no send until the frame ends
    push_src(0, 1'b1, 8'h55);
    expect_byte(0, 8'h55);
    s0  = m_sends;
    hit = 1'b0;
    for (c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      hit = bus.tx_send;
    end
    check("t5_first_send", 32'(hit), 32'd1);
    repeat (2) @(posedge clk);
    do_reset(3);
    check("t5_active_kept", 32'(bus.tx_active), 32'd1);
    push_src(0, 1'b1, 8'h66);
    expect_byte(0, 8'h66);
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.tx_active) break;
      check("t5_hold", 32'(bus.tx_send), 32'd0);
    end
    check("t5_active_fell", 32'(bus.tx_active), 32'd0);
    wait_idle("t5", 100);
    check("t5_sends", 32'(m_sends - s0), 32'd2);

    // 6: uart_tx raises active three cycles after send
    m_delay = 2;
    push_src(2, 1'b0, 8'hc1);
    push_src(2, 1'b0, 8'hc2);
    push_src(2, 1'b1, 8'hc3);
    expect_byte(2, 8'hc1);
    expect_byte(2, 8'hc2);
    expect_byte(2, 8'hc3);
    s0 = m_sends;
    wait_idle("t6", 400);
    check("t6_sends", 32'(m_sends - s0), 32'd3);
    check("t6_ptr", 32'(dbg.ptr), 32'd3);
    m_delay = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance among N_REQ byte-stream requesters. Packet-granular round-robin: a grant is held until the requester's last byte is sent, MAX_BURST bytes have gone out, or it stalls. Sequences uart_tx through its send/active handshake, so that logic moves out of each top level. Sits between per-source fifo/formatter blocks and uart_tx.

Parameters:
N_REQ, 4, number of requesters (1..8)
MAX_BURST, 16, max bytes per grant before forced release (1..255)
ACT_WAIT, 2, cycles to wait for tx_active to rise after tx_send before proceeding anyway

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a byte on its data lane
req_data  in  8*N_REQ  byte lanes; lane i = bits [8i+7:8i]
req_last  in  N_REQ  byte on lane i is the last of its packet
req_ready  out  N_REQ  one-cycle pulse: lane i byte accepted
grant  out  N_REQ  one-hot owner of uart_tx; 0 when idle
busy  out  1  state != IDLE
tx_data  out  8  byte to uart_tx
tx_send  out  1  one-cycle send pulse to uart_tx
tx_active  in  1  uart_tx frame in progress

Behaviour:
- Reset (async, rst_n=0): tx_send=0, tx_data=0, req_ready=0, grant=0, busy=0, rr pointer=0, burst count=0, state=IDLE. All outputs registered.
- States: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE: if any req_valid, pick first set bit scanning from pointer upward with wrap; register one-hot grant, burst=0 -> LOAD. Else stay.
- LOAD: if req_valid[g]=0 -> release. Else if tx_active=1 -> stay. Else sample lane g data and req_last[g]; next cycle tx_data=byte, tx_send=1, req_ready[g]=1 (both exactly one cycle); burst+1; -> WAIT_START.
- Requester rule: hold valid/data/last stable until its req_ready pulse; may change them the cycle after.
- WAIT_START: leave to WAIT_DONE when tx_active=1 or after ACT_WAIT cycles, whichever first. Prevents the send-to-active gap being read as done.
- WAIT_DONE: when tx_active=0: if sampled last=1 or burst=MAX_BURST -> release; else -> LOAD.
- Release: pointer = (g+1) mod N_REQ, grant=0 -> IDLE. One idle cycle between grants is required.
- Latency from idle: valid at cycle 0 -> grant at 1 -> tx_send/req_ready at 2 (tx idle). Back-to-back bytes in a packet: next tx_send 2 cycles after tx_active falls.
- Simultaneous requests: round-robin only. Lowest index wins only when pointer=0.
- Non-granted requesters never see req_ready. req_ready is always one-hot or zero.
- rst_n mid-frame: uart_tx is not reset and may still be active. The first LOAD after reset waits for tx_active=0, so the frame is not corrupted.
- N_REQ=1: pointer is a constant 0, with a 1-bit minimum width. Same FSM.
- Burst counter is 8 bits and saturates at MAX_BURST; it never wraps.

Decomposition:
- Package uart_arb_pkg: state encoding (IDLE, LOAD, WAIT_START, WAIT_DONE), parameter-derived pointer width (clog2 with min 1).
- Sub-module rr_pick: combinational rotate-priority search. Inputs: request vector, pointer. Outputs: one-hot pick, any. Instantiated once.

Test Plan:
1. Single packet: req0 sends 0x41,0x42(last) against a uart_tx model (active=1 for 20 cycles, starting the cycle after send). Expect two tx_send pulses with data 0x41, 0x42; two req_ready[0] pulses; grant=0001 throughout, then 0000.
2. Round-robin: reqs 0,1,2 each hold a one-byte last packet at the same cycle. Expect service order 0,1,2, then a new req0 request is served after 1 and 2. Pointer=3 after req2.
3. MAX_BURST=4: req1 streams 10 bytes with last never asserted while req2 waits. Expect 4 bytes from req1, release, 1 from req2, then req1 resumes.
4. Stall: req3 drops valid after byte 1 of a packet. Expect release in LOAD with no tx_send, and grant moves to a pending req0.
5. Reset mid-frame: rst_n low for 3 cycles while tx_active=1, then req0 valid. Expect all outputs 0 during reset, and no tx_send until tx_active falls.
6. Slow active: model raises tx_active 3 cycles after send with ACT_WAIT=2. Expect no double send and correct byte count; check one-hot req_ready every cycle.
